// File: rtl/inst_fifo.sv
// Dual-ported instruction FIFO between fetch and dual-issue decode.
// Up to two pushes and two pops per cycle; head and head+1 are always presented.
module inst_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_rst,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_inst2,
  input  logic [31:0] write_addr1,
  input  logic [31:0] write_addr2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_inst1,
  output logic [31:0] read_inst2,
  output logic [31:0] read_addr1,
  output logic [31:0] read_addr2,
  output logic        empty,
  output logic        almost_empty,
  output logic        full
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
  logic [AW:0]   count;
  logic [1:0]    wr_n, rd_req, rd_n;

  assign rd_ptr1 = rd_ptr + AW'(1);
  assign wr_ptr1 = wr_ptr + AW'(1);

  assign empty        = (count == '0);
  assign almost_empty = (count == (AW+1)'(1));
  // full leaves headroom for a dual push; a same-cycle pop does not count
  assign full         = (count >= (AW+1)'(DEPTH-1));

  always_comb begin
    wr_n = 2'd0;
    if (write_en1 && !full) wr_n = write_en2 ? 2'd2 : 2'd1;
  end

  always_comb begin
    rd_req = 2'd0;
    if (read_en1) rd_req = read_en2 ? 2'd2 : 2'd1;
    rd_n = rd_req;
    if (empty)                             rd_n = 2'd0;
    else if (almost_empty && rd_req == 2'd2) rd_n = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_n);
      rd_ptr <= rd_ptr + AW'(rd_n);
      count  <= count + (AW+1)'(wr_n) - (AW+1)'(rd_n);
    end
  end

  // Storage has no reset; validity is tracked purely by count
  always_ff @(posedge clk) begin
    if (!rst && !fifo_rst && wr_n != 2'd0) begin
      mem[wr_ptr] <= '{inst: write_inst1, pc: write_addr1};
      if (wr_n == 2'd2) mem[wr_ptr1] <= '{inst: write_inst2, pc: write_addr2};
    end
  end

  always_comb begin
    read_inst1 = '0;
    read_addr1 = '0;
    read_inst2 = '0;
    read_addr2 = '0;
    if (count >= (AW+1)'(1)) begin
      read_inst1 = mem[rd_ptr].inst;
      read_addr1 = mem[rd_ptr].pc;
    end
    if (count >= (AW+1)'(2)) begin
      read_inst2 = mem[rd_ptr1].inst;
      read_addr2 = mem[rd_ptr1].pc;
    end
  end

endmodule

// File: tb/tb_inst_fifo.sv
// Directed self-checking bench for inst_fifo (DEPTH=16).
module tb_inst_fifo;
  logic        clk = 1'b0;
  logic        rst, fifo_rst;
  logic        write_en1, write_en2, read_en1, read_en2;
  logic [31:0] write_inst1, write_inst2, write_addr1, write_addr2;
  logic [31:0] read_inst1, read_inst2, read_addr1, read_addr2;
  logic        empty, almost_empty, full;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inst_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .fifo_rst(fifo_rst),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_inst1(write_inst1), .write_inst2(write_inst2),
    .write_addr1(write_addr1), .write_addr2(write_addr2),
    .read_en1(read_en1), .read_en2(read_en2),
    .read_inst1(read_inst1), .read_inst2(read_inst2),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .empty(empty), .almost_empty(almost_empty), .full(full)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; fifo_rst = 0;
    write_en1 = 0; write_en2 = 0; read_en1 = 0; read_en2 = 0;
    write_inst1 = '0; write_inst2 = '0; write_addr1 = '0; write_addr2 = '0;
  endtask

  // apply the currently driven inputs for one edge, sample #1 after it
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push2(input logic [31:0] i1, a1, i2, a2);
    write_en1 = 1; write_en2 = 1;
    write_inst1 = i1; write_addr1 = a1; write_inst2 = i2; write_addr2 = a2;
    cyc();
  endtask

  task automatic push1(input logic [31:0] i1, a1);
    write_en1 = 1; write_inst1 = i1; write_addr1 = a1;
    cyc();
  endtask

  task automatic pop(input logic two);
    read_en1 = 1; read_en2 = two;
    cyc();
  endtask

  initial begin
    idle();
    @(negedge clk);
    // 1. reset
    rst = 1;
    cyc();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_aempty", 64'(almost_empty), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_inst1", 64'(read_inst1), 64'd0);
    chk("rst_inst2", 64'(read_inst2), 64'd0);
    chk("rst_addr1", 64'(read_addr1), 64'd0);

    // 2. dual push, dual pop
    push2(32'h11111111, 32'hBFC00000, 32'h22222222, 32'hBFC00004);
    chk("dp_count", 64'(dut.count), 64'd2);
    chk("dp_inst1", 64'(read_inst1), 64'h11111111);
    chk("dp_inst2", 64'(read_inst2), 64'h22222222);
    chk("dp_addr1", 64'(read_addr1), 64'hBFC00000);
    chk("dp_addr2", 64'(read_addr2), 64'hBFC00004);
    chk("dp_empty", 64'(empty), 64'd0);
    pop(1);
    chk("dpop_empty", 64'(empty), 64'd1);
    chk("dpop_inst1", 64'(read_inst1), 64'd0);

    // 3. single push; dual pop clamps to one; pop on empty is a no-op
    push1(32'h33333333, 32'hBFC00008);
    chk("sp_aempty", 64'(almost_empty), 64'd1);
    chk("sp_inst1", 64'(read_inst1), 64'h33333333);
    chk("sp_inst2", 64'(read_inst2), 64'd0);
    chk("sp_addr2", 64'(read_addr2), 64'd0);
    pop(1);
    chk("sp_pop_empty", 64'(empty), 64'd1);
    chk("sp_pop_count", 64'(dut.count), 64'd0);
    pop(1);
    chk("uflow_count", 64'(dut.count), 64'd0);
    chk("uflow_rdptr", 64'(dut.rd_ptr), 64'd3);
    // write_en2 alone ignored
    write_en2 = 1; write_inst2 = 32'hDEAD0000;
    cyc();
    chk("we2only_empty", 64'(empty), 64'd1);

    // 4. fill to full (pointers start at 3)
    for (int j = 0; j < 7; j++)
      push2(32'hA0000000 + 32'(2*j), 32'h1000 + 32'(8*j),
            32'hA0000001 + 32'(2*j), 32'h1004 + 32'(8*j));
    chk("fill14_count", 64'(dut.count), 64'd14);
    chk("fill14_full", 64'(full), 64'd0);
    push2(32'hA000000E, 32'h1038, 32'hA000000F, 32'h103C);
    chk("fill16_count", 64'(dut.count), 64'd16);
    chk("fill16_full", 64'(full), 64'd1);
    push2(32'hBAD00000, 32'h0, 32'hBAD00001, 32'h0);
    chk("drop_count", 64'(dut.count), 64'd16);
    chk("drop_head", 64'(read_inst1), 64'hA0000000);
    pop(0);
    chk("pop15_count", 64'(dut.count), 64'd15);
    chk("pop15_full", 64'(full), 64'd1);
    chk("pop15_head", 64'(read_inst1), 64'hA0000001);
    push1(32'hBAD00002, 32'h0);
    chk("drop15_count", 64'(dut.count), 64'd15);
    // full at registered count blocks a push even with a same-cycle pop
    write_en1 = 1; write_inst1 = 32'hBAD00003; read_en1 = 1;
    cyc();
    chk("pushpop_full_count", 64'(dut.count), 64'd14);
    chk("pop14_full", 64'(full), 64'd0);
    chk("pop14_head", 64'(read_inst1), 64'hA0000002);
    chk("pop14_next", 64'(read_addr2), 64'h100C);
    for (int j = 0; j < 6; j++) pop(1);
    chk("tail_inst1", 64'(read_inst1), 64'hA000000E);
    chk("tail_inst2", 64'(read_inst2), 64'hA000000F);
    pop(1);
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_rdptr", 64'(dut.rd_ptr), 64'd3);

    // 5. wrap-around: move pointers to 15
    for (int j = 0; j < 6; j++) push2(32'h0, 32'h0, 32'h0, 32'h0);
    for (int j = 0; j < 6; j++) pop(1);
    chk("wrap_rdptr", 64'(dut.rd_ptr), 64'd15);
    push2(32'hC0000015, 32'h2015, 32'hC0000000, 32'h2000);
    chk("wrap_wrptr", 64'(dut.wr_ptr), 64'd1);
    chk("wrap_inst1", 64'(read_inst1), 64'hC0000015);
    chk("wrap_inst2", 64'(read_inst2), 64'hC0000000);
    chk("wrap_addr2", 64'(read_addr2), 64'h2000);
    push2(32'hC0000001, 32'h2001, 32'hC0000002, 32'h2002);
    chk("wrap_wrptr3", 64'(dut.wr_ptr), 64'd3);
    // simultaneous dual pop straddling 15->0 and dual push
    read_en1 = 1; read_en2 = 1;
    write_en1 = 1; write_en2 = 1;
    write_inst1 = 32'hC0000003; write_addr1 = 32'h2003;
    write_inst2 = 32'hC0000004; write_addr2 = 32'h2004;
    cyc();
    chk("pp_count", 64'(dut.count), 64'd4);
    chk("pp_inst1", 64'(read_inst1), 64'hC0000001);
    chk("pp_inst2", 64'(read_inst2), 64'hC0000002);
    chk("pp_addr1", 64'(read_addr1), 64'h2001);

    // 6. flush mid-traffic beats same-cycle reads and writes
    push1(32'hC0000005, 32'h2005);
    chk("fl_pre_count", 64'(dut.count), 64'd5);
    fifo_rst = 1; read_en1 = 1;
    write_en1 = 1; write_en2 = 1;
    write_inst1 = 32'hEEEE0001; write_inst2 = 32'hEEEE0002;
    cyc();
    chk("fl_empty", 64'(empty), 64'd1);
    chk("fl_count", 64'(dut.count), 64'd0);
    chk("fl_inst1", 64'(read_inst1), 64'd0);
    chk("fl_wrptr", 64'(dut.wr_ptr), 64'd0);
    push1(32'h77777777, 32'h3000);
    chk("postfl_inst1", 64'(read_inst1), 64'h77777777);
    chk("postfl_inst2", 64'(read_inst2), 64'd0);
    chk("postfl_count", 64'(dut.count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
